// File: rtl/serial_word_transmitter.sv
// rtl/serial_word_transmitter.sv - parallel-in serial-out word transmitter driving a shift-register receiver
module serial_word_transmitter #(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_dir,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             so,
  output logic [1:0]       sel_out,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int CW = $clog2(BIT_CYCLES) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic             dir;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    cyc_cnt;
  logic             strobe;

  // Strobe marks the last clock of a bit period; the receiver latches so on that edge.
  assign strobe = (state == S_SHIFT) && (cyc_cnt == CYC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      dir     <= 1'b0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_valid) begin
            state   <= S_SHIFT;
            shreg   <= tx_data;
            dir     <= tx_dir;
            bit_cnt <= '0;
            cyc_cnt <= '0;
          end
        end
        S_SHIFT: begin
          if (strobe) begin
            cyc_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= dir ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
            end
          end else begin
            cyc_cnt <= cyc_cnt + CW'(1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The outgoing bit sits at the end of the register that faces the chosen direction.
  assign so       = (state == S_SHIFT) && (dir ? shreg[0] : shreg[WIDTH-1]);
  assign sel_out  = strobe ? (dir ? 2'b10 : 2'b01) : 2'b00;
  assign tx_ready = (state == S_IDLE);
  assign busy     = (state == S_SHIFT) || (state == S_DONE);
  assign done     = (state == S_DONE);

endmodule

// File: tb/tb_serial_word_transmitter.sv
// tb/tb_serial_word_transmitter.sv - self-checking bench for serial_word_transmitter
module tb_serial_word_transmitter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] tx_data = '0;
  logic         tx_dir = 1'b0;
  logic         valid1 = 1'b0, valid3 = 1'b0;
  logic         ready1, so1, busy1, done1;
  logic         ready3, so3, busy3, done3;
  logic [1:0]   sel1, sel3;

  serial_word_transmitter #(.WIDTH(W), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_dir(tx_dir), .tx_valid(valid1),
    .tx_ready(ready1), .so(so1), .sel_out(sel1), .busy(busy1), .done(done1));

  serial_word_transmitter #(.WIDTH(W), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_dir(tx_dir), .tx_valid(valid3),
    .tx_ready(ready3), .so(so3), .sel_out(sel3), .busy(busy3), .done(done3));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Receiver models (universal shift register) and scoreboards for both instances.
  logic [W-1:0] po1 = '0, po3 = '0;
  logic [W-1:0] q1[$], q3[$];
  int done_cnt1 = 0, done_cnt3 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      po1 = '0;
      po3 = '0;
    end else begin
      check("sel1_never_11", {31'd0, sel1 == 2'b11}, 32'd0);
      check("sel3_never_11", {31'd0, sel3 == 2'b11}, 32'd0);
      if (valid1 && ready1) q1.push_back(tx_data);
      if (valid3 && ready3) q3.push_back(tx_data);
      if (sel1 == 2'b01) po1 = {po1[W-2:0], so1};
      else if (sel1 == 2'b10) po1 = {so1, po1[W-1:1]};
      if (sel3 == 2'b01) po3 = {po3[W-2:0], so3};
      else if (sel3 == 2'b10) po3 = {so3, po3[W-1:1]};
      if (done1) begin
        done_cnt1++;
        if (q1.size() == 0) check("sb1_unexpected_done", 32'd1, 32'd0);
        else check("sb1_po", {28'd0, po1}, {28'd0, q1.pop_front()});
      end
      if (done3) begin
        done_cnt3++;
        if (q3.size() == 0) check("sb3_unexpected_done", 32'd1, 32'd0);
        else check("sb3_po", {28'd0, po3}, {28'd0, q3.pop_front()});
      end
    end
  end

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] d);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = d[W-1-i];
    return r;
  endfunction

  // One frame with full cycle-by-cycle timing checks; cycle 1 is the cycle after the handshake edge.
  task automatic run_frame(input logic [W-1:0] d, input logic dir, input bit use3,
                           input logic [W-1:0] exp_seq, input int exp_done, input string tag);
    int bc = use3 ? 3 : 1;
    int guard = 0, strobe_err = 0, so_err = 0, done_at = -1;
    logic [W-1:0] got = '0;
    logic s_so, s_done;
    logic [1:0] s_sel;
    tx_data = d;
    tx_dir  = dir;
    if (use3) valid3 = 1'b1; else valid1 = 1'b1;
    do begin
      @(negedge clk);
      guard++;
    end while (!(use3 ? ready3 : ready1) && guard < 50);
    if (guard >= 50) check({tag, "_handshake_timeout"}, 32'd1, 32'd0);
    after_edge();
    valid1 = 1'b0;
    valid3 = 1'b0;
    tx_data = ~d;
    tx_dir  = ~dir;
    for (int c = 1; c <= W * bc + 3; c++) begin
      @(negedge clk);
      s_so   = use3 ? so3 : so1;
      s_sel  = use3 ? sel3 : sel1;
      s_done = use3 ? done3 : done1;
      if (c <= W * bc) begin
        if (s_so !== exp_seq[W-1-((c-1)/bc)]) so_err++;
        if (c % bc == 0) begin
          if (s_sel !== (dir ? 2'b10 : 2'b01)) strobe_err++;
          got = {got[W-2:0], s_so};
        end else if (s_sel !== 2'b00) strobe_err++;
      end else if (s_sel !== 2'b00) strobe_err++;
      if (s_done === 1'b1 && done_at < 0) done_at = c;
    end
    check({tag, "_bits"}, {28'd0, got}, {28'd0, exp_seq});
    check({tag, "_so_hold_errs"}, so_err, 0);
    check({tag, "_strobe_errs"}, strobe_err, 0);
    check({tag, "_done_cycle"}, done_at, exp_done);
    after_edge();
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         dir;
    bit           use3;
    logic [W-1:0] seq;
    int           done_lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d1, d3, c_at;
    vecs[0] = '{4'b1011, 1'b0, 1'b0, 4'b1011, 5};
    vecs[1] = '{4'b1011, 1'b1, 1'b0, 4'b1101, 5};
    vecs[2] = '{4'b0110, 1'b0, 1'b1, 4'b0110, 13};
    vecs[3] = '{4'b0011, 1'b1, 1'b1, 4'b1100, 13};
    vecs[4] = '{4'b1000, 1'b1, 1'b0, 4'b0001, 5};

    #1;
    check("rst_ready1", {31'd0, ready1}, 32'd1);
    check("rst_outs1", {27'd0, so1, sel1, busy1, done1}, 32'd0);
    check("rst_ready3", {31'd0, ready3}, 32'd1);
    check("rst_outs3", {27'd0, so3, sel3, busy3, done3}, 32'd0);
    after_edge();
    after_edge();
    rst_n = 1'b1;
    after_edge();

    for (int i = 0; i < 5; i++)
      run_frame(vecs[i].data, vecs[i].dir, vecs[i].use3, vecs[i].seq, vecs[i].done_lat, $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of a frame.
    tx_data = 4'b1111;
    tx_dir  = 1'b0;
    valid3  = 1'b1;
    after_edge();
    valid3 = 1'b0;
    after_edge();
    after_edge();
    check("midframe_busy", {31'd0, busy3}, 32'd1);
    d3 = done_cnt3;
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", {31'd0, ready3}, 32'd1);
    check("async_rst_outs", {27'd0, so3, sel3, busy3, done3}, 32'd0);
    after_edge();
    after_edge();
    q3.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) after_edge();
    check("rst_no_done", done_cnt3, d3);
    check("rst_idle_after", {31'd0, ready3}, 32'd1);

    // tx_valid held high: back-to-back frames with one DONE gap, mid-frame data change ignored.
    d1 = done_cnt1;
    tx_data = 4'hA;
    tx_dir  = 1'b0;
    valid1  = 1'b1;
    @(negedge clk);
    check("b2b_ready_at_start", {31'd0, ready1}, 32'd1);
    after_edge();
    tx_data = 4'h5;
    c_at = -1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 5) check("b2b_done_c5", {31'd0, done1}, 32'd1);
      if (ready1 === 1'b1 && c_at < 0) c_at = c;
      if (c == 7) check("b2b_busy_c7", {31'd0, busy1}, 32'd1);
    end
    check("b2b_idle_gap_cycle", c_at, 6);
    after_edge();
    valid1 = 1'b0;
    for (int i = 0; i < 10; i++) after_edge();
    check("b2b_frames", done_cnt1 - d1, 2);

    // Random frames on both instances.
    for (int i = 0; i < 200; i++) begin
      logic [W-1:0] d;
      logic dr;
      bit u3;
      d  = W'($urandom);
      dr = 1'($urandom);
      u3 = 1'($urandom);
      run_frame(d, dr, u3, dr ? rev(d) : d, u3 ? 3 * W + 1 : W + 1, "rnd");
    end

    check("sb1_drained", q1.size(), 0);
    check("sb3_drained", q3.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
